// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
//
// Front-end sequencer for the 8-point FFT stage datapath.
//
// The block collects eight serial samples into a parallel frame (s0..s7).
// When the frame is complete it issues a one-cycle launch pulse, and the stage
// datapath captures frame_out in that cycle. The datapath has a fixed latency
// of LAT cycles and cannot stall. For that reason a launch is only issued
// when the downstream result buffer has a free slot (a credit). If no credit
// is available the completed frame is parked (WAIT). While parked, in_ready is
// low and frame_out is held until a credit is returned.
//
// Parameters
//   N        sample width is 2**N bits
//   LAT      cycles from the launch cycle to the result-valid cycle (>= 1)
//   CREDITS  number of downstream result-buffer slots (1..7)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   in_valid   in   serial sample offered
//   in_ready   out  registered; sample accepted when in_valid & in_ready
//   in_data    in   sample; 1st accepted of a frame -> s0, 8th -> s7
//   frame_out  out  packed frame, s0 in the LSBs, s7 in the MSBs
//   launch     out  one-cycle pulse, datapath captures frame_out this cycle
//   res_valid  out  one-cycle pulse LAT cycles after each launch
//   res_pop    in   downstream freed one result slot (returns a credit)
//   credits    out  free credits, 0..CREDITS
//   inflight   out  launches whose result pulse is still in the delay line
//   err_pop    out  sticky: res_pop seen while credits were already full
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
  parameter int N       = 4,
  parameter int LAT     = 3,
  parameter int CREDITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**N-1:0]       in_data,
  output logic [8*(2**N)-1:0]   frame_out,
  output logic                  launch,
  output logic                  res_valid,
  input  logic                  res_pop,
  output logic [2:0]            credits,
  output logic [2:0]            inflight,
  output logic                  err_pop
);

  localparam int         W        = 2**N;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t         state;
  logic [2:0]     idx;
  logic [W-1:0]   slot [8];
  logic [LAT-1:0] lat_sr;

  logic accept;
  logic credit_avail;

  assign accept = in_valid & in_ready;

  // A pop in the deciding cycle counts as a credit, even though the
  // registered count only catches up at the next edge. A launch never falls
  // in the same cycle as a decision: the launch cycle is always slot 0 of the
  // following frame. So the registered count never overstates what is free.
  assign credit_avail = (credits != 3'd0) | res_pop;

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs of this block are registered.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FILL;
      idx      <= 3'd0;
      in_ready <= 1'b0;
      launch   <= 1'b0;
    end else begin
      launch <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            // idx wraps 7 -> 0, so the next frame starts at s0 either way.
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              if (credit_avail) begin
                launch <= 1'b1;
              end else begin
                state    <= WAIT;
                in_ready <= 1'b0;
              end
            end
          end
        end
        WAIT: begin
          in_ready <= 1'b0;
          if (credit_avail) begin
            launch   <= 1'b1;
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          idx      <= 3'd0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Frame slots. While parked in WAIT, in_ready is low, so nothing is
  // written and the frame stays stable. A sample accepted in the launch
  // cycle lands at the closing edge of that cycle, after the datapath has
  // already captured the frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        slot[i] <= '0;
      end
    end else if (accept) begin
      slot[idx] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pack
      assign frame_out[gi*W +: W] = slot[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Credit accounting. Updated at the closing edge of the launch cycle.
  // A pop with credits already full and no launch is ignored and flagged.
  // A pop together with a launch is a net zero change, even at full.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits <= CRED_MAX;
      err_pop <= 1'b0;
    end else begin
      case ({launch, res_pop})
        2'b10: begin
          if (credits != 3'd0) begin
            credits <= credits - 3'd1;
          end
        end
        2'b01: begin
          if (credits == CRED_MAX) begin
            err_pop <= 1'b1;
          end else begin
            credits <= credits + 3'd1;
          end
        end
        default: begin
          credits <= credits;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result timing. The pipeline latency is modelled by a LAT-deep delay line
  // of launch pulses. Clearing it on reset drops any pre-reset results.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_sr <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        lat_sr[i] <= lat_sr[i-1];
      end
      lat_sr[0] <= launch;
    end
  end

  assign res_valid = lat_sr[LAT-1];

  always_comb begin
    inflight = 3'd0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + {2'b00, lat_sr[i]};
    end
  end

endmodule
